dmem_dump_arbiter: RTL and testbench

Shares the single-port data memory between the pipeline MEM stage and the debug unit's memory-dump engine.
- The CPU always wins the port.
- On a start pulse, the dump engine walks addresses 0..RAM_DEPTH-1 in otherwise idle cycles and streams each word out over a valid/ready handshake.
- Sits between the MEM stage, the debug/UART unit and the data memory.

---
 rtl/dmem_dump_arbiter.sv | 144 ++++++++++++++
 tb/tb_dmem_dump_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_dump_arbiter.sv
// Data-memory port arbiter: the CPU MEM stage always owns the port, and a debug dump engine
// reads words 0..RAM_DEPTH-1 in idle cycles. Optional starvation guard: DUMP_STARVE_GUARD_EN.
module dmem_dump_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int RAM_DEPTH    = 128,
  parameter int STARVE_LIMIT = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_cpu_valid,
  input  logic                  i_cpu_read,
  input  logic                  i_cpu_write,
  input  logic [ADDR_WIDTH-1:0] i_cpu_addr,
  input  logic [DATA_WIDTH-1:0] i_cpu_wdata,
  output logic [DATA_WIDTH-1:0] o_cpu_rdata,
  input  logic                  i_dump_start,
  input  logic                  i_dump_ready,
  output logic                  o_dump_valid,
  output logic [DATA_WIDTH-1:0] o_dump_data,
  output logic [ADDR_WIDTH-1:0] o_dump_addr,
  output logic                  o_dump_busy,
  output logic                  o_dump_done,
  output logic                  o_mem_valid,
  output logic                  o_mem_read_enable,
  output logic                  o_mem_write_enable,
  output logic [ADDR_WIDTH-1:0] o_mem_address,
  output logic [DATA_WIDTH-1:0] o_mem_write_data,
`ifdef DUMP_STARVE_GUARD_EN
  output logic                  o_cpu_stall,
`endif
  input  logic [DATA_WIDTH-1:0] i_mem_read_data
);

  // state | meaning
  // IDLE  | no dump in progress, waiting for start
  // ISSUE | dump read pending, waits for a cycle without CPU access
  // WAIT  | dump read in flight, capture data at end of cycle
  // HOLD  | word presented on valid/ready, waiting for acceptance
  // DONE  | one-cycle completion pulse
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD, S_DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] dump_addr;
  logic [DATA_WIDTH-1:0] cpu_rdata_q;
  logic                  cpu_rd_q;
  logic                  cpu_access;
  logic                  dump_grant;
  logic                  stall;

  assign cpu_access = i_cpu_valid && (i_cpu_read || i_cpu_write);

`ifdef DUMP_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] starve_cnt;

  // Down-counter of blocked ISSUE cycles; terminal count forces the dump read through.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n)
      starve_cnt <= CW'(STARVE_LIMIT);
    else if (dump_grant)
      starve_cnt <= CW'(STARVE_LIMIT);
    else if (state == S_ISSUE && cpu_access && starve_cnt != '0)
      starve_cnt <= starve_cnt - 1'b1;
  end

  assign stall       = (state == S_ISSUE) && cpu_access && (starve_cnt == '0);
  assign o_cpu_stall = stall;
`else
  assign stall = 1'b0;
`endif

  assign dump_grant = (state == S_ISSUE) && (!cpu_access || stall);

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) state <= S_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt          = state;
    o_mem_valid        = 1'b0;
    o_mem_read_enable  = 1'b0;
    o_mem_write_enable = 1'b0;
    o_mem_address      = '0;
    o_mem_write_data   = '0;
    case (state)
      S_IDLE:  if (i_dump_start) state_nxt = S_ISSUE;
      S_ISSUE: if (dump_grant) state_nxt = S_WAIT;
      S_WAIT:  state_nxt = S_HOLD;
      S_HOLD:  if (i_dump_ready) state_nxt = (dump_addr == LAST_ADDR) ? S_DONE : S_ISSUE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (cpu_access && !stall) begin
      o_mem_valid        = 1'b1;
      o_mem_read_enable  = i_cpu_read;
      o_mem_write_enable = i_cpu_write;
      o_mem_address      = i_cpu_addr;
      o_mem_write_data   = i_cpu_wdata;
    end else if (dump_grant) begin
      o_mem_valid       = 1'b1;
      o_mem_read_enable = 1'b1;
      o_mem_address     = dump_addr;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      dump_addr   <= '0;
      o_dump_data <= '0;
      o_dump_addr <= '0;
    end else begin
      if (state == S_IDLE && i_dump_start)
        dump_addr <= '0;
      if (state == S_WAIT) begin
        o_dump_data <= i_mem_read_data;
        o_dump_addr <= dump_addr;
      end
      if (state == S_HOLD && i_dump_ready && dump_addr != LAST_ADDR)
        dump_addr <= dump_addr + 1'b1;
    end
  end

  // Keep the last CPU load result so dump reads never disturb what the pipeline sees.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      cpu_rd_q    <= 1'b0;
      cpu_rdata_q <= '0;
    end else begin
      cpu_rd_q <= cpu_access && i_cpu_read && !stall;
      if (cpu_rd_q)
        cpu_rdata_q <= i_mem_read_data;
    end
  end

  assign o_cpu_rdata  = cpu_rd_q ? i_mem_read_data : cpu_rdata_q;
  assign o_dump_valid = (state == S_HOLD);
  assign o_dump_busy  = (state != S_IDLE);
  assign o_dump_done  = (state == S_DONE);

endmodule

// File: tb/tb_dmem_dump_arbiter.sv
// Directed bench for dmem_dump_arbiter with a registered-read memory model initialised to mem[i]=i.
// Define DUMP_STARVE_GUARD_EN on both files to exercise the starvation guard.
module tb_dmem_dump_arbiter;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int DEPTH = 128;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cpu_valid, cpu_read, cpu_write;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          dump_start, dump_ready, dump_valid, dump_busy, dump_done;
  logic [DW-1:0] dump_data;
  logic [AW-1:0] dump_addr;
  logic          mem_valid, mem_re, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
`ifdef DUMP_STARVE_GUARD_EN
  logic          cpu_stall;
`endif

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] exp_mem [DEPTH];
  int n_checks = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_dump_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH), .STARVE_LIMIT(16)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_cpu_valid(cpu_valid), .i_cpu_read(cpu_read), .i_cpu_write(cpu_write),
    .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata), .o_cpu_rdata(cpu_rdata),
    .i_dump_start(dump_start), .i_dump_ready(dump_ready), .o_dump_valid(dump_valid),
    .o_dump_data(dump_data), .o_dump_addr(dump_addr), .o_dump_busy(dump_busy),
    .o_dump_done(dump_done), .o_mem_valid(mem_valid), .o_mem_read_enable(mem_re),
    .o_mem_write_enable(mem_we), .o_mem_address(mem_addr), .o_mem_write_data(mem_wdata),
`ifdef DUMP_STARVE_GUARD_EN
    .o_cpu_stall(cpu_stall),
`endif
    .i_mem_read_data(mem_rdata)
  );

  // Registered-read memory: read data next cycle, write commits at the edge.
  always @(posedge clk) begin
    if (mem_valid && mem_re) mem_rdata <= mem[mem_addr[6:0]];
    if (mem_valid && mem_we) mem[mem_addr[6:0]] <= mem_wdata;
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic cpu_idle();
    cpu_valid = 0; cpu_read = 0; cpu_write = 0; cpu_addr = '0; cpu_wdata = '0;
  endtask

  // Entered at the negedge of the ISSUE cycle with no CPU traffic and ready=1; leaves one
  // negedge after the HOLD cycle, enforcing the 3-cycle cadence.
  task automatic do_word(input int k);
    check("issue_valid", mem_valid, 1);
    check("issue_re", mem_re, 1);
    check("issue_addr", mem_addr, k);
    @(negedge clk);
    check("wait_valid", dump_valid, 0);
    @(negedge clk);
    check("hold_valid", dump_valid, 1);
    check("hold_addr", dump_addr, k);
    check("hold_data", dump_data, exp_mem[k]);
    check("hold_done", dump_done, 0);
    @(negedge clk);
  endtask

  task automatic start_dump();
    dump_start = 1;
    @(negedge clk);
    dump_start = 0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = i;
      exp_mem[i] = i;
    end
    cpu_idle();
    rst_n = 0; dump_start = 0; dump_ready = 1;
    @(negedge clk); @(negedge clk);
    check("rst_busy", dump_busy, 0);
    check("rst_valid", dump_valid, 0);
    check("rst_done", dump_done, 0);
    check("rst_data", dump_data, 0);
    check("rst_addr", dump_addr, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_mem_valid", mem_valid, 0);
    rst_n = 1;
    @(negedge clk);
    check("idle_busy", dump_busy, 0);

    // Full dump with no traffic.
    start_dump();
    check("t1_busy", dump_busy, 1);
    for (int k = 0; k < DEPTH; k++) do_word(k);
    check("t1_done", dump_done, 1);
    check("t1_done_busy", dump_busy, 1);
    @(negedge clk);
    check("t1_done_clear", dump_done, 0);
    check("t1_busy_fall", dump_busy, 0);

    // Second dump: backpressure at 5, CPU load collision at 7, stores at 20.
    start_dump();
    for (int k = 0; k < 5; k++) do_word(k);
    check("t2_issue5", mem_addr, 5);
    dump_ready = 0;
    @(negedge clk); @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      check("t2_stall_valid", dump_valid, 1);
      check("t2_stall_data", dump_data, 5);
      check("t2_stall_addr", dump_addr, 5);
      @(negedge clk);
    end
    dump_ready = 1;
    #1;
    check("t2_release_valid", dump_valid, 1);
    @(negedge clk);
    do_word(6);

    cpu_valid = 1; cpu_read = 1; cpu_addr = 3;
    #1;
    check("t3_cpu_wins_addr", mem_addr, 3);
    check("t3_cpu_wins_re", mem_re, 1);
    @(negedge clk);
    cpu_idle();
    #1;
    check("t3_cpu_rdata", cpu_rdata, 3);
    do_word(7);
    check("t3_cpu_rdata_held", cpu_rdata, 3);

    for (int k = 8; k < 20; k++) begin
      dump_start = (k == 10);
      do_word(k);
    end
    dump_start = 0;
    cpu_valid = 1; cpu_write = 1; cpu_addr = 100; cpu_wdata = 32'hDEADBEEF;
    #1;
    check("t4_we", mem_we, 1);
    check("t4_re", mem_re, 0);
    check("t4_wdata", mem_wdata, 32'hDEADBEEF);
    exp_mem[100] = 32'hDEADBEEF;
    @(negedge clk);
    cpu_addr = 2; cpu_wdata = 32'h12345678;
    @(negedge clk);
    cpu_idle();
    #1;
    for (int k = 20; k <= 100; k++) do_word(k);
    check("t4_word2_dumped", exp_mem[2], 2);
    cpu_valid = 1; cpu_read = 1; cpu_addr = 2;
    @(negedge clk);
    cpu_idle();
    #1;
    check("t4_mem2_updated", cpu_rdata, 32'h12345678);

    // Reset in HOLD of word 101.
    check("t5_issue101", mem_addr, 101);
    @(negedge clk); @(negedge clk);
    check("t5_in_hold", dump_valid, 1);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    check("t5_valid", dump_valid, 0);
    check("t5_busy", dump_busy, 0);
    check("t5_done", dump_done, 0);
    check("t5_data", dump_data, 0);
    check("t5_addr", dump_addr, 0);
    @(negedge clk);
    check("t5_idle_busy", dump_busy, 0);
    check("t5_idle_done", dump_done, 0);
    start_dump();
    do_word(0);

    // CPU reads every cycle while the dump waits to issue word 1.
    cpu_valid = 1; cpu_read = 1; cpu_addr = 50;
    #1;
`ifdef DUMP_STARVE_GUARD_EN
    for (int i = 0; i < 16; i++) begin
      check("t6_no_stall", cpu_stall, 0);
      check("t6_blocked_addr", mem_addr, 50);
      @(negedge clk);
    end
    check("t6_stall", cpu_stall, 1);
    check("t6_forced_addr", mem_addr, 1);
    check("t6_forced_re", mem_re, 1);
    @(negedge clk);
    check("t6_stall_clear", cpu_stall, 0);
    check("t6_cpu_back", mem_addr, 50);
    check("t6_cpu_rdata_kept", cpu_rdata, 50);
    @(negedge clk);
    check("t6_hold_valid", dump_valid, 1);
    check("t6_hold_data", dump_data, 1);
    @(negedge clk);
    cpu_idle();
    #1;
    do_word(2);
`else
    for (int i = 0; i < 40; i++) begin
      check("t6_starved_valid", dump_valid, 0);
      check("t6_starved_addr", mem_addr, 50);
      @(negedge clk);
    end
    check("t6_starved_busy", dump_busy, 1);
    check("t6_cpu_rdata", cpu_rdata, 50);
    cpu_idle();
    #1;
    do_word(1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
